spram_fifo_ctrl: RTL and testbench
==================================

SPRAM_FIFO_CTRL -- requirements
Module: spram_fifo_ctrl

Interface
REQ-001 Parameter DATA_W, default 128, SHALL set stream and RAM data width.
REQ-002 Parameter ADDR_W, default 3, SHALL set RAM address width; RAM depth is 2**ADDR_W (8).
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 s_valid, s_ready, s_data  in/out/in  1/1/DATA_W  upstream push stream.
REQ-006 m_valid, m_ready, m_data  out/in/out  1/1/DATA_W  downstream pop stream.
REQ-007 ram_wr_en, ram_addr, ram_data_in  out/out/out  1/ADDR_W/DATA_W  drive the single-port RAM.
REQ-008 ram_data_out  input  DATA_W  RAM read data, valid the cycle after a read is issued (ram_wr_en=0).
REQ-009 count, full, empty  out/out/out  ADDR_W+1/1/1  total occupancy (RAM plus output register), RAM full, all empty.

Function
REQ-010 Storage: RAM FIFO of 8 entries plus one output register driving m_data; total capacity 9.
REQ-011 Exactly one RAM access per cycle: write, read, or none.
REQ-012 FSM states: IDLE, RD_PEND; IDLE->RD_PEND when a read is issued; RD_PEND->IDLE unconditionally next cycle, loading ram_data_out into output register.
REQ-013 Read issue (rd_go) SHALL be asserted in IDLE when ram_cnt>0 and (!m_valid or m_ready); drives ram_wr_en=0, ram_addr=rd_ptr; rd_ptr increments.
REQ-014 s_ready SHALL equal !full && !rd_go (combinational; m_ready->s_ready path permitted).
REQ-015 Push (s_valid && s_ready): ram_wr_en=1, ram_addr=wr_ptr, ram_data_in=s_data; wr_ptr increments.
REQ-016 Read beats write: on simultaneous rd_go and s_valid the push SHALL stall, no data lost.
REQ-017 Pointers SHALL wrap modulo 8; ram_cnt SHALL be 0..8, full = (ram_cnt==8).
REQ-018 Pop (m_valid && m_ready) SHALL clear output register unless reloaded same cycle.
REQ-019 m_data SHALL stay stable while m_valid && !m_ready.
REQ-020 Idle cycles SHALL drive ram_wr_en=0, ram_addr held.
REQ-021 Latency push->m_valid: 3 cycles (write t, read t+1, load t+2, m_valid t+3).
REQ-022 empty = (count==0); count SHALL change by at most +1/-1 per cycle in net.

Reset
REQ-023 rst SHALL clear wr_ptr, rd_ptr, ram_cnt, output register valid, FSM to IDLE; m_data SHALL reset to 0.
REQ-024 Reset outputs: m_valid=0, s_ready=0 during rst, count=0, empty=1, full=0, ram_wr_en=0, ram_addr=0.
REQ-025 rst during RD_PEND SHALL discard the in-flight read; RAM contents need not be cleared.

Configuration
REQ-026 Macro SPRAM_FIFO_BYPASS_EN defined: when count==0, FSM IDLE and push occurs, s_data SHALL load the output register directly (no RAM write), m_valid next cycle (latency 1).
REQ-027 Macro undefined: all data SHALL pass through RAM; latency per REQ-021.

Structure
REQ-028 Shared package spram_fifo_pkg SHALL hold the FSM state enum (IDLE, RD_PEND) and default DATA_W/ADDR_W constants.
REQ-029 The single-port RAM SHALL be instantiated outside this block; no sub-module inside except an optional ptr_counter for wr_ptr/rd_ptr.

Verification
REQ-030 Reset then idle 5 cycles -> m_valid=0, empty=1, count=0, ram_wr_en=0.
REQ-031 Push 0xA5 at cycle 0, m_ready=1 -> m_valid at cycle 3 with m_data=0xA5 (cycle 1 with BYPASS_EN).
REQ-032 Push 9 words 1..9 with m_ready=0 -> full=1 after 8 RAM entries plus output loaded, count=9, s_ready=0; then m_ready=1 -> pops 1..9 in order.
REQ-033 Continuous push/pop for 20 words across pointer wrap -> output sequence equals input sequence, no drops, no duplicates.
REQ-034 m_ready held low 4 cycles while m_valid=1 -> m_data unchanged; s_valid concurrent with rd_go -> s_ready=0 that cycle, word accepted later.
REQ-035 Assert rst during RD_PEND with count=3 -> next cycle count=0, m_valid=0, subsequent push 0x77 emerges intact.

Source files
------------

// File: rtl/spram_fifo_pkg.sv
// rtl/spram_fifo_pkg.sv - shared types and default sizes for the single-port RAM FIFO controller
//
// Purpose : holds the read-FSM state enum and the default data/address widths
//           used by spram_fifo_ctrl.
// Ports   : none (package).
package spram_fifo_pkg;

  localparam int DEF_DATA_W = 128;
  localparam int DEF_ADDR_W = 3;

  typedef enum logic {
    IDLE    = 1'b0,
    RD_PEND = 1'b1
  } fsm_state_t;

endpackage

// File: rtl/spram_fifo_ctrl.sv
// rtl/spram_fifo_ctrl.sv - FIFO controller around an external single-port RAM with an output register
//
// Purpose : 2**ADDR_W-entry FIFO kept in an external single-port RAM, followed by
//           one output register that drives the pop stream (total capacity 2**ADDR_W+1).
//           One RAM access per cycle; a pending read has priority over a push.
// Config  : define SPRAM_FIFO_BYPASS_EN to let a push into a completely empty,
//           idle FIFO load the output register directly (latency 1 instead of 3).
// Ports   : clk, rst            - clock, synchronous active-high reset
//           s_valid/s_ready/s_data - push stream in
//           m_valid/m_ready/m_data - pop stream out
//           ram_wr_en/ram_addr/ram_data_in - RAM command; ram_data_out - RAM read data
//           count/full/empty    - total occupancy, RAM full, all empty
module spram_fifo_ctrl
  import spram_fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              ram_wr_en,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data_in,
  input  logic [DATA_W-1:0] ram_data_out,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty
);

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  fsm_state_t        state, state_next;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr, addr_q;
  logic [ADDR_W:0]   ram_cnt;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              rd_go, push, push_ram, bypass, pop, load;

  // A read may only be issued when the output register will be free by the
  // time the data returns (empty now, or being popped this cycle).
  assign rd_go    = !rst && (state == IDLE) && (ram_cnt != '0) && (!out_valid || m_ready);
  assign full     = (ram_cnt == DEPTH);
  assign s_ready  = !rst && !full && !rd_go;
  assign push     = s_valid && s_ready;
  assign load     = (state == RD_PEND);
  assign pop      = out_valid && m_ready;

`ifdef SPRAM_FIFO_BYPASS_EN
  // count==0 already implies no RAM entries, nothing in flight and an empty output register.
  assign bypass   = push && (state == IDLE) && (count == '0);
`else
  assign bypass   = 1'b0;
`endif

  assign push_ram    = push && !bypass;
  assign ram_wr_en   = push_ram;
  assign ram_data_in = s_data;
  assign ram_addr    = rst      ? '0     :
                       rd_go    ? rd_ptr :
                       push_ram ? wr_ptr : addr_q;

  // The word in flight during RD_PEND is counted so occupancy never dips.
  assign count   = ram_cnt + (ADDR_W+1)'(out_valid) + (ADDR_W+1)'(state == RD_PEND);
  assign empty   = (count == '0);
  assign m_valid = out_valid;
  assign m_data  = out_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (rd_go) state_next = RD_PEND;
      RD_PEND: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      addr_q    <= '0;
      ram_cnt   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (push_ram) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (rd_go)    rd_ptr <= rd_ptr + ADDR_W'(1);
      if (rd_go || push_ram) addr_q <= ram_addr;

      if (push_ram)   ram_cnt <= ram_cnt + (ADDR_W+1)'(1);
      else if (rd_go) ram_cnt <= ram_cnt - (ADDR_W+1)'(1);

      // Load and bypass never coincide (RD_PEND vs IDLE); the register is
      // always free at load time, so a pop cannot race a load.
      if (load) begin
        out_valid <= 1'b1;
        out_data  <= ram_data_out;
      end else if (bypass) begin
        out_valid <= 1'b1;
        out_data  <= s_data;
      end else if (pop) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spram_fifo_ctrl.sv
// tb/tb_spram_fifo_ctrl.sv - self-checking bench for spram_fifo_ctrl with a RAM model and queue reference
module tb_spram_fifo_ctrl;

  localparam int DW = 128;
  localparam int AW = 3;
`ifdef SPRAM_FIFO_BYPASS_EN
  localparam int LAT = 1;
  localparam bit BYP = 1'b1;
`else
  localparam int LAT = 3;
  localparam bit BYP = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          s_valid, s_ready, m_valid, m_ready, ram_wr_en, full, empty;
  logic [DW-1:0] s_data, m_data, ram_data_in, ram_data_out;
  logic [AW-1:0] ram_addr;
  logic [AW:0]   count;

  spram_fifo_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .ram_wr_en(ram_wr_en), .ram_addr(ram_addr), .ram_data_in(ram_data_in),
    .ram_data_out(ram_data_out),
    .count(count), .full(full), .empty(empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port RAM: write, or registered read one cycle later.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    ram_data_out = '0;
  end
  always @(posedge clk) begin
    if (ram_wr_en) mem[ram_addr] <= ram_data_in;
    else           ram_data_out  <= mem[ram_addr];
  end

  int            n_vec = 0;
  int            n_bad = 0;
  logic [DW-1:0] q[$];
  logic [DW-1:0] popped[$];
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data  = '0;
  logic          last_push  = 1'b0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs after the edge, check at the falling edge, then
  // apply the handshakes that the next rising edge will commit to the model.
  task automatic cycle(input logic sv, input logic [DW-1:0] sd, input logic mr, input logic r);
    @(posedge clk); #1;
    rst = r; s_valid = sv; s_data = sd; m_ready = mr;
    @(negedge clk);
    if (r) chk("s_ready_in_rst", s_ready, 0);
    chk("count", count, q.size());
    chk("empty", empty, q.size() == 0);
    if (full) chk("full_count", count >= 8, 1);
    if (q.size() == 9) chk("s_ready_at_cap", s_ready, 0);
    if (m_valid) begin
      if (q.size() > 0) chk("m_data", m_data, q[0]);
      else              chk("m_valid_on_empty", m_valid, 0);
    end
    if (prev_stall) begin
      chk("hold_valid", m_valid, 1);
      chk("hold_data", m_data, prev_data);
    end
    if (BYP) begin
      if (ram_wr_en) chk("wr_needs_push", s_valid && s_ready, 1);
    end else begin
      chk("ram_wr_en", ram_wr_en, s_valid && s_ready);
    end
    if (ram_wr_en) chk("ram_wdata", ram_data_in, s_data);
    last_push = 1'b0;
    if (r) begin
      q.delete();
      prev_stall = 1'b0;
    end else begin
      if (m_valid && m_ready && q.size() > 0) popped.push_back(q.pop_front());
      if (s_valid && s_ready) begin
        q.push_back(s_data);
        last_push = 1'b1;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && q.size() > 0; i++) cycle(0, '0, 1, 0);
    chk("drain_done", q.size(), 0);
  endtask

  initial begin
    int            lat;
    int            d;
    logic [DW-1:0] w;

    rst = 1'b1; s_valid = 1'b0; m_ready = 1'b0; s_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_ram_wr_en", ram_wr_en, 0);
    chk("rst_ram_addr", ram_addr, 0);

    // Idle after reset.
    for (int i = 0; i < 5; i++) begin
      cycle(0, '0, 0, 0);
      chk("idle_m_valid", m_valid, 0);
      chk("idle_ram_wr_en", ram_wr_en, 0);
    end
    chk("idle_ram_addr", ram_addr, 0);

    // Single-word latency.
    cycle(1, 'hA5, 1, 0);
    chk("a5_accepted", last_push, 1);
    lat = -1;
    for (int k = 1; k <= 8; k++) begin
      cycle(0, '0, 1, 0);
      if (m_valid && lat < 0) begin
        lat = k;
        chk("a5_data", m_data, 'hA5);
      end
    end
    chk("latency", lat, LAT);

    // Fill to capacity with the consumer stalled, then drain in order.
    drain();
    popped.delete();
    d = 1;
    for (int i = 0; i < 60 && d <= 9; i++) begin
      cycle(1, d, 0, 0);
      if (last_push) d++;
    end
    chk("fill_words", d, 10);
    cycle(1, 10, 0, 0);
    chk("fill_full", full, 1);
    chk("fill_count", count, 9);
    chk("fill_s_ready", s_ready, 0);
    drain();
    chk("fill_pop_n", popped.size(), 9);
    for (int i = 0; i < popped.size(); i++) chk("fill_order", popped[i], i + 1);

    // Continuous streaming across pointer wrap.
    popped.delete();
    d = 0;
    for (int i = 0; i < 300 && (d < 20 || q.size() > 0); i++) begin
      cycle(d < 20, 100 + d, 1, 0);
      if (last_push) d++;
    end
    chk("stream_pop_n", popped.size(), 20);
    for (int i = 0; i < popped.size(); i++) chk("stream_order", popped[i], 100 + i);

    // Stalled output holds its data; a read issue blocks a concurrent push.
    cycle(1, 'h11, 0, 0);
    chk("w11_accepted", last_push, 1);
    for (int i = 0; i < 10 && !m_valid; i++) cycle(0, '0, 0, 0);
    chk("w11_visible", m_valid, 1);
    for (int i = 0; i < 4; i++) begin
      cycle(0, '0, 0, 0);
      chk("stall_data", m_data, 'h11);
    end
    cycle(1, 'h22, 0, 0);
    chk("w22_accepted", last_push, 1);
    popped.delete();
    cycle(1, 'h33, 1, 0);
    chk("rd_beats_wr", s_ready, 0);
    for (int i = 0; i < 10 && !last_push; i++) cycle(1, 'h33, 1, 0);
    chk("w33_accepted", last_push, 1);
    drain();
    chk("stall_pop_n", popped.size(), 3);
    if (popped.size() == 3) begin
      chk("stall_pop0", popped[0], 'h11);
      chk("stall_pop1", popped[1], 'h22);
      chk("stall_pop2", popped[2], 'h33);
    end

    // Reset while a read is in flight.
    d = 0;
    for (int i = 0; i < 30 && q.size() < 4; i++) begin
      cycle(1, 'h41 + d, 0, 0);
      if (last_push) d++;
    end
    chk("pre_fill", q.size(), 4);
    cycle(0, '0, 1, 0);
    cycle(0, '0, 0, 1);
    chk("pre_rst_count", count, 3);
    cycle(0, '0, 0, 0);
    chk("post_rst_count", count, 0);
    chk("post_rst_m_valid", m_valid, 0);
    popped.delete();
    cycle(1, 'h77, 1, 0);
    chk("w77_accepted", last_push, 1);
    drain();
    chk("w77_pop_n", popped.size(), 1);
    if (popped.size() == 1) chk("w77_data", popped[0], 'h77);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      w = {$urandom(), $urandom(), $urandom(), $urandom()};
      cycle($urandom_range(0, 99) < ((i / 150) % 2 ? 80 : 40), w,
            $urandom_range(0, 99) < ((i / 100) % 2 ? 30 : 70), 0);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
